// File: rtl/raiz_pkg.sv
// Shared types and constants for the square-root request scheduler.
package raiz_pkg;

    localparam int unsigned RAIZ_W       = 16;
    localparam int unsigned WDOG_MAX_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter must be able to hold WDOG_MAX.
    function automatic int unsigned wdog_width(int unsigned max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/raiz_sched_if.sv
// Requester-side handshakes plus the root-unit port of the scheduler.
interface raiz_sched_if
    import raiz_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = RAIZ_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [N_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]       resp_q;
    logic [DATA_W-1:0]       resp_r;
    logic                    resp_err;
    logic                    sq_init;
    logic [DATA_W-1:0]       sq_rr;
    logic [DATA_W-1:0]       sq_q;
    logic [DATA_W-1:0]       sq_r;
    logic                    sq_done;

    modport master (
        output req_valid, req_data, resp_ready, sq_q, sq_r, sq_done,
        input  req_ready, resp_valid, resp_q, resp_r, resp_err, sq_init, sq_rr
    );

    modport slave (
        input  req_valid, req_data, resp_ready, sq_q, sq_r, sq_done,
        output req_ready, resp_valid, resp_q, resp_r, resp_err, sq_init, sq_rr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after ptr, wrapping.
module rr_arbiter
    import raiz_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/raiz_sched.sv
// Round-robin scheduler sharing one square-root unit among N_REQ requesters,
// with a watchdog that aborts an operation whose done never arrives.
module raiz_sched
    import raiz_pkg::*;
#(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned DATA_W   = RAIZ_W,
    parameter  int unsigned WDOG_MAX = WDOG_MAX_DEF,
    localparam int unsigned IDX_W    = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    raiz_sched_if.slave      bus,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id
);

    localparam int unsigned CNT_W = wdog_width(WDOG_MAX);

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n, gid_n, win_idx;
    logic [N_REQ-1:0]  win_grant, rv_n;
    logic              win_any;
    logic [DATA_W-1:0] ops [N_REQ];
    logic [DATA_W-1:0] rr_n, q_n, r_n;
    logic              err_n, init_n;
    logic [CNT_W-1:0]  wdog, wdog_n;

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_ops
        assign ops[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .index (win_idx),
        .any   (win_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            grant_id       <= '0;
            wdog           <= '0;
            busy           <= 1'b0;
            bus.sq_init    <= 1'b0;
            bus.sq_rr      <= '0;
            bus.resp_valid <= '0;
            bus.resp_q     <= '0;
            bus.resp_r     <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            grant_id       <= gid_n;
            wdog           <= wdog_n;
            busy           <= (state_n != S_IDLE);
            bus.sq_init    <= init_n;
            bus.sq_rr      <= rr_n;
            bus.resp_valid <= rv_n;
            bus.resp_q     <= q_n;
            bus.resp_r     <= r_n;
            bus.resp_err   <= err_n;
        end
    end

    // Next-state and next register values; req_ready is the only same-cycle output.
    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        gid_n         = grant_id;
        wdog_n        = wdog;
        init_n        = 1'b0;
        rr_n          = bus.sq_rr;
        rv_n          = bus.resp_valid;
        q_n           = bus.resp_q;
        r_n           = bus.resp_r;
        err_n         = bus.resp_err;
        bus.req_ready = '0;
        unique case (state)
            S_IDLE: begin
                if (win_any) begin
                    bus.req_ready = win_grant;
                    rr_n          = ops[win_idx];
                    gid_n         = win_idx;
                    init_n        = 1'b1;
                    state_n       = S_START;
                end
            end
            S_START: state_n = S_GUARD;
            // Done may still be high from the previous operation; skip it here.
            S_GUARD: begin
                wdog_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.sq_done) begin
                    q_n     = bus.sq_q;
                    r_n     = bus.sq_r;
                    err_n   = 1'b0;
                    rv_n    = N_REQ'(1) << grant_id;
                    state_n = S_RESP;
                end else if (wdog == CNT_W'(WDOG_MAX - 1)) begin
                    q_n     = '0;
                    r_n     = '0;
                    err_n   = 1'b1;
                    rv_n    = N_REQ'(1) << grant_id;
                    state_n = S_RESP;
                end else begin
                    wdog_n = wdog + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready[grant_id]) begin
                    rv_n    = '0;
                    ptr_n   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
